// File: rtl/key_fifo_dev.sv
// Memory-mapped key controller: per-key synchronizer and debouncer feeding a
// press/release event FIFO with status, overflow and interrupt control.

module key_fifo_lane #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic press,
  output logic rel
);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [1:0]    sync, warm;
  logic          stable, armed, flip;
  logic [CW-1:0] cnt;

  assign flip  = (sync[1] != stable) && (cnt == CW'(DEB_CYCLES - 1));
  // A key held through reset stays unarmed until it is seen stably released.
  assign press = flip & stable & armed;
  assign rel   = flip & ~stable & armed;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync   <= 2'b11;
      warm   <= 2'b00;
      stable <= 1'b1;
      armed  <= 1'b0;
      cnt    <= '0;
    end else begin
      sync <= {sync[0], key};
      warm <= {warm[0], 1'b1};
      if (warm[1] && sync[1] && stable) armed <= 1'b1;
      if (sync[1] == stable) cnt <= '0;
      else if (flip) begin
        stable <= ~stable;
        cnt    <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

module key_fifo_dev #(
  parameter int DBITS      = 32,
  parameter int NKEYS      = 4,
  parameter int DEPTH      = 8,
  parameter int DEB_CYCLES = 16,
  parameter int CTRL_RDY   = 0,
  parameter int CTRL_OVR   = 1,
  parameter int CTRL_IE    = 2,
  parameter int CTRL_RLS   = 3,
  parameter int CTRL_CNT   = 8,
  parameter logic [DBITS-1:0] KEYDATAADDR = 32'hFFFFF080,
  parameter logic [DBITS-1:0] KEYCTRLADDR = 32'hFFFFF084
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic             sw,
  input  logic [DBITS-1:0] addrbus,
  inout  wire  [DBITS-1:0] databus,
  input  logic [NKEYS-1:0] KEY,
  output logic             KEYIRQ
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2 * NKEYS;

  logic [NKEYS-1:0] press_mask, rel_mask;
  logic [EW-1:0]    ev;
  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             ovr, ie, rls;
  logic             sel_data, sel_ctrl, full, push, pop, ovr_set;
  logic [DBITS-1:0] rdata;
  logic             unused_bus;

  for (genvar i = 0; i < NKEYS; i++) begin : g_lane
    key_fifo_lane #(.DEB_CYCLES(DEB_CYCLES)) u_lane (
      .clk   (clk),
      .reset (reset),
      .key   (KEY[i]),
      .press (press_mask[i]),
      .rel   (rel_mask[i])
    );
  end

  assign ev       = {rel_mask & {NKEYS{rls}}, press_mask};
  assign sel_data = (addrbus == KEYDATAADDR);
  assign sel_ctrl = (addrbus == KEYCTRLADDR);
  assign full     = (count == (AW+1)'(DEPTH));
  assign pop      = ld && sel_data && (count != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push     = (ev != '0) && (!full || pop);
  assign ovr_set  = (ev != '0) && full && !pop;
  assign KEYIRQ   = (count != '0) && ie;

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= ev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovr    <= 1'b0;
      ie     <= 1'b0;
      rls    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (sw && sel_ctrl) begin
        ie  <= databus[CTRL_IE];
        rls <= databus[CTRL_RLS];
        ovr <= ovr & databus[CTRL_OVR];
      end
      if (ovr_set) ovr <= 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    if (sel_data) begin
      if (count != '0) rdata[EW-1:0] = mem[rd_ptr];
    end else if (sel_ctrl) begin
      rdata[CTRL_RDY]          = (count != '0);
      rdata[CTRL_OVR]          = ovr;
      rdata[CTRL_IE]           = ie;
      rdata[CTRL_RLS]          = rls;
      rdata[CTRL_CNT +: AW+1]  = count;
    end
  end

  assign databus    = (ld && (sel_data || sel_ctrl)) ? rdata : 'z;
  assign unused_bus = ^databus;
endmodule

// File: tb/tb_key_fifo_dev.sv
// Randomized scoreboard bench for key_fifo_dev: a queue-based model predicts
// every bus read; a negedge monitor compares whatever the DUT drives.

module tb_key_fifo_dev;
  localparam int NK = 4;
  localparam int DEPTH = 8;
  localparam logic [31:0] DA = 32'hFFFFF080;
  localparam logic [31:0] CA = 32'hFFFFF084;

  logic clk = 0, reset = 0, ld = 0, sw = 0, drv = 0;
  logic [31:0] addrbus = '0, wdata = '0;
  wire  [31:0] databus;
  logic [NK-1:0] KEY = '1;
  logic KEYIRQ;

  assign databus = drv ? wdata : 'z;

  key_fifo_dev dut (
    .clk(clk), .reset(reset), .ld(ld), .sw(sw), .addrbus(addrbus),
    .databus(databus), .KEY(KEY), .KEYIRQ(KEYIRQ)
  );

  always #5 clk = ~clk;

  int compared = 0, mismatched = 0;

  typedef struct {
    logic [31:0] exp;
    bit          is_ctrl;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // Reference model: event queue plus control bits and logical key state.
  int mq[$];
  bit m_ovr = 0, m_ie = 0, m_rls = 0;
  logic [NK-1:0] m_held = '0, m_dead = '0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (ld) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_read: got %h expected no read", databus);
      end else begin
        mon_e = sb.pop_front();
        check(mon_e.is_ctrl ? "ctrl_rd" : "data_rd", databus, mon_e.exp);
      end
    end
  end

  function automatic logic [31:0] ctrl_exp();
    return {20'd0, 4'(mq.size()), 4'd0, m_rls, m_ie, m_ovr, mq.size() != 0};
  endfunction

  function automatic void model_event(logic [7:0] ev);
    if (ev == 0) return;
    if (mq.size() == DEPTH) m_ovr = 1;
    else mq.push_back(int'(ev));
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_irq();
    check("irq", 32'(KEYIRQ), 32'(m_ie && mq.size() != 0));
  endtask

  task automatic rd(logic [31:0] a);
    exp_t e;
    e.is_ctrl = (a == CA);
    e.exp = '0;
    if (a == CA) e.exp = ctrl_exp();
    else if (mq.size() != 0) e.exp = 32'(mq.pop_front());
    sb.push_back(e);
    ld = 1; addrbus = a;
    tick(1);
    ld = 0;
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d);
    sw = 1; addrbus = a; wdata = d; drv = 1;
    tick(1);
    sw = 0; drv = 0;
    if (a == CA) begin
      m_ie = d[2];
      m_rls = d[3];
      m_ovr = m_ovr & d[1];
    end
  endtask

  // Drive a new pressed set and let it settle well past the debounce window.
  task automatic set_keys(logic [NK-1:0] n);
    logic [NK-1:0] pm, rm;
    pm = n & ~m_held;
    rm = m_held & ~n & ~m_dead;
    m_dead = m_dead & n;
    KEY = ~n;
    tick(24);
    model_event({m_rls ? rm : 4'b0, pm});
    m_held = n;
  endtask

  task automatic do_reset();
    reset = 0;
    #1;
    check("irq_in_reset", 32'(KEYIRQ), 32'd0);
    tick(1);
    reset = 1;
    mq.delete();
    m_ovr = 0; m_ie = 0; m_rls = 0;
    m_dead = m_held;
    tick(3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] masks [9];
    logic [NK-1:0] n;
    int r;
    masks = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h5, 4'h6, 4'h9, 4'hC};

    tick(2);
    check("irq_reset", 32'(KEYIRQ), 32'd0);
    reset = 1;
    tick(3);
    rd(CA);

    // single press of key 2, release ignored with RLS=0
    set_keys(4'b0100);
    set_keys(4'b0000);
    rd(DA);
    rd(CA);

    // short glitch never reaches the FIFO
    KEY[0] = 0;
    tick(10);
    KEY[0] = 1;
    tick(24);
    rd(CA);

    // press and release events with interrupt enabled
    wr(CA, 32'hC);
    set_keys(4'b0010);
    check_irq();
    set_keys(4'b0000);
    rd(CA);
    rd(DA);
    check_irq();
    rd(DA);
    check_irq();

    // overflow, OVR clear, then push during pop on a full FIFO
    wr(CA, 32'h0);
    for (int i = 0; i < 9; i++) begin
      set_keys(masks[i]);
      set_keys(4'b0000);
    end
    rd(CA);
    wr(CA, 32'h0);
    rd(CA);
    KEY = ~4'hA;
    tick(17);
    rd(DA);
    tick(6);
    model_event(8'h0A);
    m_held = 4'hA;
    rd(CA);
    set_keys(4'b0000);
    for (int i = 0; i < 8; i++) rd(DA);
    rd(CA);

    // reset with entries queued
    set_keys(4'b0001); set_keys(4'b0000);
    set_keys(4'b0010); set_keys(4'b0000);
    set_keys(4'b0100); set_keys(4'b0000);
    wr(CA, 32'h4);
    check_irq();
    do_reset();
    rd(CA);
    check_irq();
    rd(DA);

    // key held through reset produces nothing until re-pressed
    set_keys(4'b0001);
    do_reset();
    tick(24);
    rd(CA);
    wr(CA, 32'h8);
    set_keys(4'b0000);
    rd(CA);
    set_keys(4'b0001);
    rd(DA);
    set_keys(4'b0000);
    rd(DA);

    // randomized traffic
    wr(CA, 32'h0);
    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        n = 4'($urandom_range(0, 15));
        set_keys(n);
      end else if (r <= 7) begin
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) rd(DA);
      end else if (r == 8) begin
        rd(CA);
      end else begin
        case ($urandom_range(0, 2))
          0: wr(CA, {28'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'b0});
          1: wr(DA, 32'hFF);
          default: wr(32'hFFFFF088, 32'hF);
        endcase
      end
      check_irq();
    end
    rd(CA);
    tick(2);
    check("sb_drain", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
